iob_mem_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one IOb native slave port among N_MASTERS IOb native master ports, one transaction at a time. It sits between the CPU-side instruction and data splits and the single external-memory controller, so both buses reach DDR through one port. It can also front any other shared single-port IOb slave, such as a DMA engine plus the CPU on external memory. It is pure control plus muxing: no buffering of data, one outstanding transaction.

---
 rtl/iob_mem_rr_arbiter.sv | 136 +++++++++++++
 tb/tb_iob_mem_rr_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_mem_rr_arbiter.sv
// Round-robin arbiter sharing one IOb native slave port among N_MASTERS masters.
// One outstanding transaction, no data buffering; the grant is registered in IDLE.
module iob_mem_rr_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic                         clk_i,
  input  logic                         arst_i,
  input  logic                         cke_i,
  input  logic [N_MASTERS-1:0]         m_avalid_i,
  input  logic [N_MASTERS*ADDR_W-1:0]  m_addr_i,
  input  logic [N_MASTERS*DATA_W-1:0]  m_wdata_i,
  input  logic [N_MASTERS*DATA_W/8-1:0] m_wstrb_i,
  output logic [N_MASTERS*DATA_W-1:0]  m_rdata_o,
  output logic [N_MASTERS-1:0]         m_rvalid_o,
  output logic [N_MASTERS-1:0]         m_ready_o,
  output logic                         s_avalid_o,
  output logic [ADDR_W-1:0]            s_addr_o,
  output logic [DATA_W-1:0]            s_wdata_o,
  output logic [DATA_W/8-1:0]          s_wstrb_o,
  input  logic [DATA_W-1:0]            s_rdata_i,
  input  logic                         s_rvalid_i,
  input  logic                         s_ready_i,
  output logic [N_MASTERS-1:0]         grant_o,
  output logic                         busy_o
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] last;
  logic [IDX_W-1:0] next_idx;
  logic             any_req;
  logic             is_write;

  // Search last+1, last+2, ... modulo N_MASTERS; the first requester found wins.
  always_comb begin
    int cand;
    cand     = 0;
    next_idx = last;
    any_req  = 1'b0;
    for (int i = 1; i <= N_MASTERS; i++) begin
      cand = (int'(last) + i) % N_MASTERS;
      if (!any_req && m_avalid_i[IDX_W'(cand)]) begin
        any_req  = 1'b1;
        next_idx = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    s_avalid_o = 1'b0;
    s_addr_o   = '0;
    s_wdata_o  = '0;
    s_wstrb_o  = '0;
    m_ready_o  = '0;
    m_rvalid_o = '0;
    case (state)
      ADDR: begin
        s_avalid_o     = m_avalid_i[idx];
        s_addr_o       = m_addr_i[int'(idx)*ADDR_W +: ADDR_W];
        s_wdata_o      = m_wdata_i[int'(idx)*DATA_W +: DATA_W];
        s_wstrb_o      = m_wstrb_i[int'(idx)*STRB_W +: STRB_W];
        m_ready_o[idx] = s_ready_i;
      end
      RESP: begin
        m_rvalid_o[idx] = s_rvalid_i;
      end
      default: begin
      end
    endcase
  end

  assign is_write  = |s_wstrb_o;
  assign m_rdata_o = {N_MASTERS{s_rdata_i}};

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state   <= IDLE;
      idx     <= '0;
      last    <= IDX_W'(N_MASTERS - 1);
      grant_o <= '0;
      busy_o  <= 1'b0;
    end else if (cke_i) begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state   <= ADDR;
            idx     <= next_idx;
            last    <= next_idx;
            grant_o <= N_MASTERS'(1) << next_idx;
            busy_o  <= 1'b1;
          end
        end
        ADDR: begin
          // A master withdrawing before acceptance never reaches the slave.
          if (!m_avalid_i[idx]) begin
            state   <= IDLE;
            grant_o <= '0;
            busy_o  <= 1'b0;
          end else if (s_ready_i) begin
            if (is_write) begin
              state   <= IDLE;
              grant_o <= '0;
              busy_o  <= 1'b0;
            end else begin
              state <= RESP;
            end
          end
        end
        RESP: begin
          if (s_rvalid_i) begin
            state   <= IDLE;
            grant_o <= '0;
            busy_o  <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          grant_o <= '0;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iob_mem_rr_arbiter.sv
// Directed bench for iob_mem_rr_arbiter with two masters; expected values are hand-computed.
module tb_iob_mem_rr_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic            clk_i = 1'b0;
  logic            arst_i;
  logic            cke_i;
  logic [N-1:0]    m_avalid_i;
  logic [N*AW-1:0] m_addr_i;
  logic [N*DW-1:0] m_wdata_i;
  logic [N*SW-1:0] m_wstrb_i;
  logic [N*DW-1:0] m_rdata_o;
  logic [N-1:0]    m_rvalid_o;
  logic [N-1:0]    m_ready_o;
  logic            s_avalid_o;
  logic [AW-1:0]   s_addr_o;
  logic [DW-1:0]   s_wdata_o;
  logic [SW-1:0]   s_wstrb_o;
  logic [DW-1:0]   s_rdata_i;
  logic            s_rvalid_i;
  logic            s_ready_i;
  logic [N-1:0]    grant_o;
  logic            busy_o;

  int n_chk  = 0;
  int n_pass = 0;

  iob_mem_rr_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i      (clk_i),
    .arst_i     (arst_i),
    .cke_i      (cke_i),
    .m_avalid_i (m_avalid_i),
    .m_addr_i   (m_addr_i),
    .m_wdata_i  (m_wdata_i),
    .m_wstrb_i  (m_wstrb_i),
    .m_rdata_o  (m_rdata_o),
    .m_rvalid_o (m_rvalid_o),
    .m_ready_o  (m_ready_o),
    .s_avalid_o (s_avalid_o),
    .s_addr_o   (s_addr_o),
    .s_wdata_o  (s_wdata_o),
    .s_wstrb_o  (s_wstrb_o),
    .s_rdata_i  (s_rdata_i),
    .s_rvalid_i (s_rvalid_i),
    .s_ready_i  (s_ready_i),
    .grant_o    (grant_o),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic req(input int k, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    m_addr_i[k*AW +: AW]  = a;
    m_wdata_i[k*DW +: DW] = d;
    m_wstrb_i[k*SW +: SW] = s;
    m_avalid_i[k]         = 1'b1;
  endtask

  task automatic reset_pulse();
    arst_i = 1'b1;
    settle();
    arst_i = 1'b0;
    settle();
  endtask

  initial begin
    arst_i     = 1'b1;
    cke_i      = 1'b1;
    m_avalid_i = '0;
    m_addr_i   = '0;
    m_wdata_i  = '0;
    m_wstrb_i  = '0;
    s_rdata_i  = '0;
    s_rvalid_i = 1'b0;
    s_ready_i  = 1'b0;
    #3;
    check("rst_grant", grant_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_s_avalid", s_avalid_o, 0);
    check("rst_s_addr", s_addr_o, 0);
    check("rst_m_ready", m_ready_o, 0);
    tick();
    arst_i = 1'b0;
    settle();

    // single read by master 0
    req(0, 32'h0000_1000, 32'h0, 4'h0);
    s_ready_i = 1'b1;
    settle();
    check("t1_idle_grant", grant_o, 0);
    tick();
    check("t1_grant", grant_o, 2'b01);
    check("t1_s_avalid", s_avalid_o, 1);
    check("t1_s_addr", s_addr_o, 32'h0000_1000);
    check("t1_m_ready", m_ready_o, 2'b01);
    tick();
    m_avalid_i[0] = 1'b0;
    s_ready_i = 1'b0;
    settle();
    check("t1_resp_avalid", s_avalid_o, 0);
    check("t1_resp_busy", busy_o, 1);
    check("t1_rvalid_early", m_rvalid_o, 0);
    tick();
    s_rvalid_i = 1'b1;
    s_rdata_i  = 32'hDEADBEEF;
    settle();
    check("t1_rvalid", m_rvalid_o, 2'b01);
    check("t1_rdata0", m_rdata_o[31:0], 32'hDEADBEEF);
    tick();
    s_rvalid_i = 1'b0;
    settle();
    check("t1_idle_busy", busy_o, 0);
    check("t1_idle_grant_clr", grant_o, 0);

    // contention after reset: master 0 then master 1
    reset_pulse();
    req(0, 32'h100, 32'h0, 4'h0);
    req(1, 32'h200, 32'h0, 4'h0);
    s_ready_i = 1'b1;
    tick();
    check("t2_first_grant", grant_o, 2'b01);
    check("t2_first_addr", s_addr_o, 32'h100);
    check("t2_first_ready", m_ready_o, 2'b01);
    tick();
    m_avalid_i[0] = 1'b0;
    s_rvalid_i = 1'b1;
    settle();
    check("t2_first_rvalid", m_rvalid_o, 2'b01);
    tick();
    s_rvalid_i = 1'b0;
    settle();
    check("t2_gap_idle", busy_o, 0);
    tick();
    check("t2_second_grant", grant_o, 2'b10);
    check("t2_second_addr", s_addr_o, 32'h200);
    tick();
    m_avalid_i[1] = 1'b0;
    s_rvalid_i = 1'b1;
    settle();
    check("t2_second_rvalid", m_rvalid_o, 2'b10);
    tick();
    s_rvalid_i = 1'b0;
    req(0, 32'h300, 32'h11, 4'hF);
    req(1, 32'h400, 32'h22, 4'hF);
    tick();
    check("t2_again_m0", grant_o, 2'b01);
    check("t2_again_wdata", s_wdata_o, 32'h11);
    tick();
    m_avalid_i[0] = 1'b0;
    settle();
    check("t2_write_done", busy_o, 0);
    tick();
    check("t2_again_m1", grant_o, 2'b10);
    check("t2_again_wdata1", s_wdata_o, 32'h22);
    tick();
    m_avalid_i[1] = 1'b0;
    req(1, 32'h500, 32'h33, 4'hF);
    tick();
    check("t2_m1_alone", grant_o, 2'b10);
    tick();
    m_avalid_i[1] = 1'b0;

    // back-to-back writes from master 1
    for (int i = 0; i < 4; i++) begin
      req(1, 32'h2000 + 32'(4 * i), 32'hA5A5_0000 + 32'(i), 4'hF);
      tick();
      check("t3_grant", grant_o, 2'b10);
      check("t3_wdata", s_wdata_o, 32'hA5A5_0000 + 32'(i));
      check("t3_wstrb", s_wstrb_o, 4'hF);
      check("t3_ready", m_ready_o, 2'b10);
      check("t3_rvalid", m_rvalid_o, 0);
      tick();
      check("t3_idle", busy_o, 0);
    end
    m_avalid_i[1] = 1'b0;

    // slave stall with the other master also requesting
    s_ready_i = 1'b0;
    req(0, 32'h3000, 32'h1234_5678, 4'h3);
    req(1, 32'h4000, 32'h0, 4'h0);
    tick();
    check("t4_grant", grant_o, 2'b01);
    for (int i = 0; i < 5; i++) begin
      check("t4_avalid", s_avalid_o, 1);
      check("t4_addr", s_addr_o, 32'h3000);
      check("t4_wdata", s_wdata_o, 32'h1234_5678);
      check("t4_no_ready", m_ready_o, 0);
      tick();
    end
    s_ready_i = 1'b1;
    settle();
    check("t4_ready", m_ready_o, 2'b01);
    tick();
    m_avalid_i = '0;
    settle();
    check("t4_idle", busy_o, 0);
    tick();
    check("t4_no_grant", grant_o, 0);

    // master withdraws before acceptance
    s_ready_i = 1'b0;
    req(0, 32'h5000, 32'h0, 4'h0);
    tick();
    check("tv_grant", grant_o, 2'b01);
    m_avalid_i[0] = 1'b0;
    tick();
    check("tv_idle", busy_o, 0);
    check("tv_avalid", s_avalid_o, 0);

    // reset in RESP
    s_ready_i = 1'b1;
    req(0, 32'h6000, 32'h0, 4'h0);
    tick();
    check("t5_grant", grant_o, 2'b01);
    tick();
    m_avalid_i[0] = 1'b0;
    s_ready_i = 1'b0;
    settle();
    check("t5_in_resp", busy_o, 1);
    arst_i = 1'b1;
    settle();
    check("t5_rst_grant", grant_o, 0);
    check("t5_rst_busy", busy_o, 0);
    check("t5_rst_avalid", s_avalid_o, 0);
    check("t5_rst_addr", s_addr_o, 0);
    tick();
    arst_i = 1'b0;
    s_rvalid_i = 1'b1;
    settle();
    check("t5_late_rvalid", m_rvalid_o, 0);
    tick();
    s_rvalid_i = 1'b0;
    s_ready_i = 1'b1;
    req(0, 32'h6100, 32'h44, 4'hF);
    req(1, 32'h6200, 32'h55, 4'hF);
    tick();
    check("t5_after_m0", grant_o, 2'b01);
    tick();
    m_avalid_i[0] = 1'b0;
    tick();
    check("t5_after_m1", grant_o, 2'b10);
    tick();
    m_avalid_i[1] = 1'b0;

    // clock enable low
    s_ready_i = 1'b0;
    cke_i = 1'b0;
    req(1, 32'h7000, 32'h0, 4'h0);
    tick();
    check("t6_idle_hold", grant_o, 0);
    cke_i = 1'b1;
    tick();
    check("t6_grant", grant_o, 2'b10);
    cke_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_hold_grant", grant_o, 2'b10);
      check("t6_hold_busy", busy_o, 1);
    end
    cke_i = 1'b1;
    s_ready_i = 1'b1;
    tick();
    m_avalid_i[1] = 1'b0;
    s_ready_i = 1'b0;
    s_rvalid_i = 1'b1;
    s_rdata_i = 32'hCAFE_F00D;
    settle();
    check("t6_rvalid", m_rvalid_o, 2'b10);
    check("t6_rdata1", m_rdata_o[63:32], 32'hCAFE_F00D);
    tick();
    s_rvalid_i = 1'b0;
    settle();
    check("t6_idle", busy_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
